instruction_fetch_stage: RTL and testbench

Fetch stage in front of the single-cycle/decode datapath. Holds the fetch PC, issues word addresses to a synchronous-read instruction memory, captures returned words with their PC into a 2-entry queue, and presents one instruction per cycle to decode. Supports decode back-pressure (stall) and branch/jump redirection with flush of queued and in-flight fetches.

---
 rtl/instruction_fetch_stage.sv | 121 ++++++++++++
 tb/tb_instruction_fetch_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: fetch PC, synchronous-read imem requests, 2-entry {pc, instr} queue to decode.
// Optional FETCH_MISALIGN_TRAP_EN: a misaligned redirect target sets a sticky trap and halts issue.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] instruccion_actual,
  output logic [31:0] pc_current,
  output logic [31:0] pc_next,
  output logic        misalign
);

  logic [31:0] r_fpc,      w_fpc_d;
  logic        r_inflight, w_inflight_d;
  logic [31:0] r_ipc,      w_ipc_d;
  logic        r_kill,     w_kill_d;
  logic [1:0]  r_count,    w_count_d;
  logic [31:0] r_q_pc    [2];
  logic [31:0] r_q_instr [2];
  logic [31:0] w_q_pc_d    [2];
  logic [31:0] w_q_instr_d [2];

  logic        w_misalign;
  logic        w_pop;
  logic        w_capture;
  logic        w_issue;
  logic [2:0]  w_occ;
  logic [1:0]  w_base;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign, w_misalign_d;
  assign w_misalign   = r_misalign;
  assign w_misalign_d = r_misalign | (redirect & (|redirect_pc[1:0]));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_misalign <= 1'b0;
    else        r_misalign <= w_misalign_d;
  end
`else
  logic w_unused_rpc_lsb;
  assign w_unused_rpc_lsb = ^redirect_pc[1:0];
  assign w_misalign       = 1'b0;
`endif

  assign w_pop     = (r_count != 2'd0) & ~stall;
  assign w_capture = r_inflight & ~r_kill;
  // Slots still claimed after this edge's pop; at most 2 by construction, so no underflow.
  assign w_occ     = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue   = reset & ~redirect & ~w_misalign & (w_occ < 3'd2);
  assign w_base    = r_count - {1'b0, w_pop};

  always_comb begin
    w_fpc_d      = r_fpc;
    w_ipc_d      = r_ipc;
    w_inflight_d = w_issue;
    w_kill_d     = 1'b0;
    w_count_d    = r_count;
    w_q_pc_d     = r_q_pc;
    w_q_instr_d  = r_q_instr;

    if (w_issue) begin
      w_ipc_d = r_fpc;
      w_fpc_d = r_fpc + 32'd4;
    end

    if (redirect) begin
      w_count_d = 2'd0;
      w_fpc_d   = {redirect_pc[31:2], 2'b00};
      w_kill_d  = r_inflight;
    end else begin
      if (w_pop) begin
        w_q_pc_d[0]    = r_q_pc[1];
        w_q_instr_d[0] = r_q_instr[1];
      end
      if (w_capture) begin
        w_q_pc_d[w_base[0]]    = r_ipc;
        w_q_instr_d[w_base[0]] = imem_rdata;
      end
      w_count_d = w_base + {1'b0, w_capture};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fpc        <= RESET_PC;
      r_inflight   <= 1'b0;
      r_ipc        <= 32'h0;
      r_kill       <= 1'b0;
      r_count      <= 2'd0;
      r_q_pc[0]    <= 32'h0;
      r_q_pc[1]    <= 32'h0;
      r_q_instr[0] <= 32'h0;
      r_q_instr[1] <= 32'h0;
    end else begin
      r_fpc        <= w_fpc_d;
      r_inflight   <= w_inflight_d;
      r_ipc        <= w_ipc_d;
      r_kill       <= w_kill_d;
      r_count      <= w_count_d;
      r_q_pc       <= w_q_pc_d;
      r_q_instr    <= w_q_instr_d;
    end
  end

  assign imem_req           = w_issue;
  assign imem_addr          = r_fpc;
  assign inst_valid         = (r_count != 2'd0);
  assign instruccion_actual = inst_valid ? r_q_instr[0] : 32'h0;
  assign pc_current         = inst_valid ? r_q_pc[0] : 32'h0;
  assign pc_next            = r_fpc;
  assign misalign           = w_misalign;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: queue-level reference model checked every cycle plus directed pins.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        inst_valid;
  logic [31:0] instruccion_actual;
  logic [31:0] pc_current;
  logic [31:0] pc_next;
  logic        misalign;

  int n_chk  = 0;
  int n_fail = 0;

  instruction_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk                (clk),
    .reset              (reset),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_rdata         (imem_rdata),
    .stall              (stall),
    .redirect           (redirect),
    .redirect_pc        (redirect_pc),
    .inst_valid         (inst_valid),
    .instruccion_actual (instruccion_actual),
    .pc_current         (pc_current),
    .pc_next            (pc_next),
    .misalign           (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) if (imem_req) imem_rdata <= rom(imem_addr);

  // Reference model: list of delivered-but-unconsumed instructions plus one pending response.
  logic [31:0] mq_pc [$];
  logic [31:0] mq_in [$];
  logic [31:0] m_fpc  = 32'h0;
  bit          m_pend = 1'b0;
  logic [31:0] m_ppc  = 32'h0;
  bit          m_mis  = 1'b0;

  function automatic bit m_pop();
    return (mq_pc.size() > 0) && !stall;
  endfunction

  function automatic bit m_req();
    return reset && !redirect && !m_mis &&
           (int'(mq_pc.size()) + int'(m_pend) - int'(m_pop()) < 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq_pc.delete();
      mq_in.delete();
      m_fpc  = 32'h0;
      m_pend = 1'b0;
      m_ppc  = 32'h0;
      m_mis  = 1'b0;
    end else begin
      bit pop, iss;
      pop = m_pop();
      iss = m_req();
      if (redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
`endif
        mq_pc.delete();
        mq_in.delete();
        m_pend = 1'b0;
        m_fpc  = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (pop) begin
          void'(mq_pc.pop_front());
          void'(mq_in.pop_front());
        end
        if (m_pend) begin
          mq_pc.push_back(m_ppc);
          mq_in.push_back(rom(m_ppc));
        end
        if (iss) begin
          m_pend = 1'b1;
          m_ppc  = m_fpc;
          m_fpc  = m_fpc + 32'd4;
        end else begin
          m_pend = 1'b0;
        end
      end
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    bit ev, er;
    ev = mq_pc.size() > 0;
    er = m_req();
    chk("inst_valid", inst_valid, ev);
    chk("instr", instruccion_actual, ev ? mq_in[0] : 32'h0);
    chk("pc_current", pc_current, ev ? mq_pc[0] : 32'h0);
    chk("pc_next", pc_next, m_fpc);
    chk("imem_req", imem_req, er);
    if (er) chk("imem_addr", imem_addr, m_fpc);
    chk("misalign", misalign, m_mis);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] pat;
    pat = 16'b1011_0010_0111_0100;

    repeat (2) tick();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_pc_next", pc_next, 32'h0);

    reset = 1'b1;
    #1;
    chk("pre1_req", imem_req, 1'b1);
    chk("pre1_addr", imem_addr, 32'h0);
    tick();
    chk("e1_valid", inst_valid, 1'b0);
    chk("e1_addr", imem_addr, 32'h4);
    tick();
    chk("e2_valid", inst_valid, 1'b1);
    chk("e2_pc", pc_current, 32'h0);
    chk("e2_instr", instruccion_actual, 32'h1357_9BDF);
    tick();
    chk("e3_pc", pc_current, 32'h4);
    chk("e3_instr", instruccion_actual, 32'h1357_9BDB);

    stall = 1'b1;
    repeat (5) tick();
    chk("stall_req", imem_req, 1'b0);
    chk("stall_pc", pc_current, 32'h4);
    chk("stall_next", pc_next, 32'hC);
    stall = 1'b0;
    #1;
    chk("release_req", imem_req, 1'b1);
    tick();
    chk("release_pc1", pc_current, 32'h8);
    tick();
    chk("release_pc2", pc_current, 32'hC);

    redirect = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    chk("rd_valid", inst_valid, 1'b0);
    chk("rd_next", pc_next, 32'h40);
    tick();
    tick();
    chk("rd_pc", pc_current, 32'h40);
    tick();
    chk("rd_pc2", pc_current, 32'h44);

    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("rdst_valid", inst_valid, 1'b0);
    tick();
    tick();
    chk("rdst_pc", pc_current, 32'h100);
    stall = 1'b0;
    tick();

    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    chk("wrap_pc_hi", pc_current, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc_lo", pc_current, 32'h0);

    for (int i = 0; i < 16; i++) begin
      stall = pat[i];
      tick();
    end
    stall = 1'b0;
    tick();

    redirect = 1'b1;
    redirect_pc = 32'h42;
    tick();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_flag", misalign, 1'b1);
    repeat (3) tick();
    chk("mis_req", imem_req, 1'b0);
    chk("mis_valid", inst_valid, 1'b0);
`else
    chk("mis_flag", misalign, 1'b0);
    tick();
    tick();
    chk("mis_pc", pc_current, 32'h40);
`endif

    repeat (2) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("mr_valid", inst_valid, 1'b0);
    chk("mr_next", pc_next, 32'h0);
    chk("mr_req", imem_req, 1'b0);
    chk("mr_mis", misalign, 1'b0);
    tick();
    #2;
    reset = 1'b1;
    repeat (6) tick();
    chk("mr_resume_pc", pc_current, 32'h10);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
